dot_seq_ctrl: RTL and testbench

Sequencer for the 4-lane 8-bit dot-product datapath: accepts a byte stream tagged as data or weight, assembles the 32-bit operand vectors, launches a computation when both vectors are complete, waits the datapath latency, captures the 18-bit result, and returns it as two 9-bit halves over a ready/valid handshake. Weights persist across computations, so one weight vector serves any number of data vectors. Sits between the chip I/O pins and the MAC datapath, which it drives through `mac_data`/`mac_weights` and samples through `mac_result`.

---
 rtl/dot_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_dot_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_seq_ctrl.sv
// dot_seq_ctrl: byte-stream sequencer for the 4-lane 8-bit dot-product datapath.
// Collects data/weight bytes, launches the MAC, captures the result, and returns it as two 9-bit halves.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_byte/in_valid/in_is_weight/in_ready    operand byte stream (ready/valid)
//   mac_data, mac_weights, mac_result         datapath operands and result
//   out_half/out_hi/out_valid/out_ready       result halves (ready/valid)
//   weights_valid, busy                       status flags
module dot_seq_ctrl #(
   parameter int unsigned MAC_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   input  logic        in_is_weight,
   output logic        in_ready,
   output logic [31:0] mac_data,
   output logic [31:0] mac_weights,
   input  logic [17:0] mac_result,
   output logic [8:0]  out_half,
   output logic        out_hi,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        weights_valid,
   output logic        busy
);

   typedef enum logic [1:0] {
      LOAD,
      WAIT,
      OUT_LO,
      OUT_HI
   } state_t;

   state_t      state, state_nx;
   logic [31:0] data_nx, wts_nx;
   logic [2:0]  dcnt, dcnt_nx;
   logic [2:0]  wcnt, wcnt_nx;
   logic [3:0]  wait_cnt, wait_nx;
   logic [17:0] res, res_nx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= LOAD;
         mac_data    <= '0;
         mac_weights <= '0;
         dcnt        <= '0;
         wcnt        <= '0;
         wait_cnt    <= '0;
         res         <= '0;
      end else begin
         state       <= state_nx;
         mac_data    <= data_nx;
         mac_weights <= wts_nx;
         dcnt        <= dcnt_nx;
         wcnt        <= wcnt_nx;
         wait_cnt    <= wait_nx;
         res         <= res_nx;
      end
   end

   always_comb begin
      state_nx = state;
      data_nx  = mac_data;
      wts_nx   = mac_weights;
      dcnt_nx  = dcnt;
      wcnt_nx  = wcnt;
      wait_nx  = wait_cnt;
      res_nx   = res;
      unique case (state)
         LOAD: begin
            if (in_valid) begin
               if (in_is_weight) begin
                  wts_nx = {mac_weights[23:0], in_byte};
                  // a weight byte on a full vector restarts collection
                  wcnt_nx = (wcnt == 3'd4) ? 3'd1 : wcnt + 3'd1;
               end else begin
                  // data keeps shifting once full: sliding window
                  data_nx = {mac_data[23:0], in_byte};
                  dcnt_nx = (dcnt == 3'd4) ? 3'd4 : dcnt + 3'd1;
               end
            end
            if (dcnt_nx == 3'd4 && wcnt_nx == 3'd4) begin
               state_nx = WAIT;
               wait_nx  = 4'(MAC_LATENCY);
            end
         end
         WAIT: begin
            if (wait_cnt <= 4'd1) begin
               res_nx   = mac_result;
               wait_nx  = 4'd0;
               state_nx = OUT_LO;
            end else begin
               wait_nx = wait_cnt - 4'd1;
            end
         end
         OUT_LO: begin
            if (out_ready) state_nx = OUT_HI;
         end
         OUT_HI: begin
            if (out_ready) begin
               state_nx = LOAD;
               dcnt_nx  = 3'd0;
            end
         end
         default: state_nx = LOAD;
      endcase
   end

   assign in_ready      = (state == LOAD);
   assign busy          = !in_ready;
   assign out_valid     = (state == OUT_LO) || (state == OUT_HI);
   assign out_hi        = (state == OUT_HI);
   assign weights_valid = (wcnt == 3'd4);

   always_comb begin
      out_half = 9'd0;
      if (state == OUT_LO) out_half = res[8:0];
      if (state == OUT_HI) out_half = res[17:9];
   end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
// tb_dot_seq_ctrl: scoreboard bench for dot_seq_ctrl at MAC_LATENCY 1 and 3.
// A datapath model feeds mac_result; expected halves are queued as bytes are accepted.
module tb_dot_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] in_byte = '0;
   logic in_is_weight = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic sel = 1'b0;

   logic v1, v3, or1, or3;
   logic rdy1, rdy3, hi1, hi3, ov1, ov3, wv1, wv3, bz1, bz3;
   logic [31:0] d1, d3, w1, w3;
   logic [8:0] h1, h3;
   logic [17:0] mr1, mr3;
   logic [17:0] p3 [0:1];

   logic o_in_ready, o_hi, o_valid, o_wv, o_busy;
   logic [31:0] o_data, o_wts;
   logic [8:0] o_half;

   int total = 0;
   int bad = 0;

   logic [31:0] mdata, mwts;
   int mdcnt, mwcnt;
   logic [9:0] exp_q [$];

   always #5 clk = ~clk;

   assign v1  = in_valid & ~sel;
   assign v3  = in_valid & sel;
   assign or1 = out_ready & ~sel;
   assign or3 = out_ready & sel;

   assign o_in_ready = sel ? rdy3 : rdy1;
   assign o_hi       = sel ? hi3 : hi1;
   assign o_valid    = sel ? ov3 : ov1;
   assign o_wv       = sel ? wv3 : wv1;
   assign o_busy     = sel ? bz3 : bz1;
   assign o_data     = sel ? d3 : d1;
   assign o_wts      = sel ? w3 : w1;
   assign o_half     = sel ? h3 : h1;

   function automatic logic [17:0] dot(input logic [31:0] d, input logic [31:0] w);
      int s;
      s = 0;
      for (int i = 0; i < 4; i++)
         s += int'(d[i*8 +: 8]) * int'(w[i*8 +: 8]);
      return s[17:0];
   endfunction

   // datapath model: combinational for latency 1, two register stages for latency 3
   assign mr1 = dot(d1, w1);
   always @(posedge clk) begin
      p3[0] <= dot(d3, w3);
      p3[1] <= p3[0];
   end
   assign mr3 = p3[1];

   dot_seq_ctrl #(.MAC_LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(v1),
      .in_is_weight(in_is_weight), .in_ready(rdy1), .mac_data(d1),
      .mac_weights(w1), .mac_result(mr1), .out_half(h1), .out_hi(hi1),
      .out_valid(ov1), .out_ready(or1), .weights_valid(wv1), .busy(bz1)
   );

   dot_seq_ctrl #(.MAC_LATENCY(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(v3),
      .in_is_weight(in_is_weight), .in_ready(rdy3), .mac_data(d3),
      .mac_weights(w3), .mac_result(mr3), .out_half(h3), .out_hi(hi3),
      .out_valid(ov3), .out_ready(or3), .weights_valid(wv3), .busy(bz3)
   );

   function automatic logic [9:0] pop();
      if (exp_q.size() == 0) return 10'bx;
      return exp_q.pop_front();
   endfunction

   // all tasks start and end just after a falling edge
   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mdata = '0;
      mwts = '0;
      mdcnt = 0;
      mwcnt = 0;
      exp_q.delete();
   endtask

   task automatic send(input logic [7:0] b, input logic w);
      logic [17:0] r;
      int n;
      in_byte = b;
      in_is_weight = w;
      in_valid = 1'b1;
      n = 0;
      while (!o_in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready=%b required 1", o_in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (w) begin
         mwts = {mwts[23:0], b};
         mwcnt = (mwcnt == 4) ? 1 : mwcnt + 1;
      end else begin
         mdata = {mdata[23:0], b};
         mdcnt = (mdcnt == 4) ? 4 : mdcnt + 1;
      end
      if (mdcnt == 4 && mwcnt == 4) begin
         r = dot(mdata, mwts);
         exp_q.push_back({1'b0, r[8:0]});
         exp_q.push_back({1'b1, r[17:9]});
         mdcnt = 0;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic get_half(output logic [9:0] got);
      int n;
      out_ready = 1'b1;
      n = 0;
      while (!o_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      got = {o_hi, o_half};
      if (!o_valid) begin
         total++;
         bad++;
         $display("FAIL out_timeout: out_valid=%b required 1", o_valid);
         got = 10'bx;
         return;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      sel = 1'b0;
      do_reset();
      total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", o_in_ready); end
      total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", o_valid); end
      total++; if (o_wv !== 1'b0) begin bad++; $display("FAIL rst_wv: got %b want 0", o_wv); end
      total++; if ({o_data, o_wts} !== 64'd0) begin bad++; $display("FAIL rst_vectors: got %h %h want 0", o_data, o_wts); end
      total++; if ({o_hi, o_half} !== 10'd0) begin bad++; $display("FAIL rst_half: got %h want 0", {o_hi, o_half}); end
   endtask

   task automatic test_basic();
      logic [9:0] e;
      sel = 1'b0;
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
      for (int i = 5; i <= 8; i++) send(8'(i), 1'b0);
      total++; if (o_wts !== 32'h01020304) begin bad++; $display("FAIL basic_wts: got %h want 01020304", o_wts); end
      total++; if (o_data !== 32'h05060708) begin bad++; $display("FAIL basic_data: got %h want 05060708", o_data); end
      total++; if ({o_busy, o_valid} !== 2'b10) begin bad++; $display("FAIL basic_wait: busy,valid got %b want 10", {o_busy, o_valid}); end
      @(negedge clk);
      e = pop();
      total++; if ({o_valid, o_hi, o_half} !== {1'b1, e}) begin bad++; $display("FAIL basic_lo: got %b %h want 1 %h", o_valid, {o_hi, o_half}, e); end
      total++; if (e !== 10'h046) begin bad++; $display("FAIL basic_lo_value: got %h want 046", e); end
      @(negedge clk);
      e = pop();
      total++; if ({o_valid, o_hi, o_half} !== {1'b1, e}) begin bad++; $display("FAIL basic_hi: got %b %h want 1 %h", o_valid, {o_hi, o_half}, e); end
      @(negedge clk);
      total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back: got %b want 1", o_in_ready); end
      total++; if (o_data !== 32'h05060708) begin bad++; $display("FAIL basic_data_kept: got %h want 05060708", o_data); end
   endtask

   task automatic test_weight_reuse();
      logic [9:0] g, e;
      for (int i = 0; i < 4; i++) begin
         send(8'h01, 1'b0);
         total++; if (o_wv !== 1'b1) begin bad++; $display("FAIL reuse_wv: got %b want 1", o_wv); end
      end
      for (int k = 0; k < 2; k++) begin
         get_half(g);
         e = pop();
         total++; if (g !== e) begin bad++; $display("FAIL reuse_half%0d: got %h want %h", k, g, e); end
      end
      total++; if (o_wv !== 1'b1) begin bad++; $display("FAIL reuse_wv_end: got %b want 1", o_wv); end
   endtask

   task automatic test_all_ff();
      logic [9:0] g, e;
      sel = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) send(8'hFF, 1'b1);
      for (int i = 0; i < 4; i++) send(8'hFF, 1'b0);
      for (int k = 0; k < 2; k++) begin
         get_half(g);
         e = pop();
         total++; if (g !== e) begin bad++; $display("FAIL ff_half%0d: got %h want %h", k, g, e); end
      end
      total++; if (dot(32'hFFFFFFFF, 32'hFFFFFFFF) !== 18'd260100) begin bad++; $display("FAIL ff_model: got %0d want 260100", dot(32'hFFFFFFFF, 32'hFFFFFFFF)); end
   endtask

   task automatic test_sliding();
      logic [9:0] g, e;
      sel = 1'b0;
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         send(8'(i), 1'b0);
         total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL slide_ready%0d: got %b want 1", i, o_in_ready); end
      end
      total++; if (o_data !== 32'h03040506) begin bad++; $display("FAIL slide_data: got %h want 03040506", o_data); end
      for (int i = 0; i < 4; i++) send(8'h01, 1'b1);
      total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL slide_launch: got %b want 1", o_busy); end
      for (int k = 0; k < 2; k++) begin
         get_half(g);
         e = pop();
         total++; if (g !== e) begin bad++; $display("FAIL slide_half%0d: got %h want %h", k, g, e); end
      end
      send(8'h07, 1'b1);
      total++; if (o_wv !== 1'b0) begin bad++; $display("FAIL slide_wv_drop: got %b want 0", o_wv); end
   endtask

   task automatic test_backpressure();
      logic [9:0] g, e, held;
      sel = 1'b1;
      do_reset();
      send(8'h10, 1'b1); send(8'h20, 1'b1); send(8'h30, 1'b1); send(8'h40, 1'b1);
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         total++; if ({o_busy, o_valid} !== 2'b10) begin bad++; $display("FAIL bp_wait%0d: busy,valid got %b want 10", c, {o_busy, o_valid}); end
         @(negedge clk);
      end
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_rise: got %b want 1", o_valid); end
      held = {o_hi, o_half};
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         total++; if ({o_valid, o_in_ready, o_hi, o_half} !== {2'b10, held}) begin bad++; $display("FAIL bp_hold%0d: got %b %b %h want 1 0 %h", c, o_valid, o_in_ready, {o_hi, o_half}, held); end
      end
      for (int k = 0; k < 2; k++) begin
         get_half(g);
         e = pop();
         total++; if (g !== e) begin bad++; $display("FAIL bp_half%0d: got %h want %h", k, g, e); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_in_out_hi();
      logic [9:0] g, e;
      sel = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) send(8'(i + 9), 1'b1);
      for (int i = 0; i < 4; i++) send(8'(i + 3), 1'b0);
      get_half(g);
      out_ready = 1'b0;
      e = pop();
      total++; if (g !== e) begin bad++; $display("FAIL rhi_lo: got %h want %h", g, e); end
      total++; if ({o_valid, o_hi} !== 2'b11) begin bad++; $display("FAIL rhi_state: got %b want 11", {o_valid, o_hi}); end
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      total++; if ({o_valid, o_wv, o_in_ready} !== 3'b001) begin bad++; $display("FAIL rhi_flags: valid,wv,ready got %b want 001", {o_valid, o_wv, o_in_ready}); end
      total++; if ({o_data, o_wts} !== 64'd0) begin bad++; $display("FAIL rhi_vectors: got %h %h want 0", o_data, o_wts); end
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rhi_no_half%0d: got %b want 0", c, o_valid); end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_weight_reuse();
      test_all_ff();
      test_sliding();
      test_backpressure();
      test_reset_in_out_hi();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
